exe_mem_stage: RTL and testbench
================================

// Module: exe_mem_stage
// PURPOSE
//  EXE->MEM boundary, directly downstream of the ALU. Captures ALU result, control
//  and store data into a 2-entry skid buffer with valid/ready handshake toward MEM
//  (MEM stalls on SRAM waits). Owns the CPSR flag register ({Z,C,N,V}) updated from
//  the ALU status output, and returns it to EXE for cin and condition checks.
// PARAMETERS
//  REGISTER_LEN  32  datapath width (shared define)
//  REG_ADDR_W    4   destination register index width
// PORTS
//  clk            in   1             rising-edge clock
//  rst_n          in   1             asynchronous, active-low reset
//  exe_valid      in   1             EXE presents an instruction
//  exe_ready      out  1             stage can accept (registered)
//  exe_alu_out    in   REGISTER_LEN  ALU result / memory address
//  exe_status     in   4             ALU flags {Z,C,N,V}
//  exe_s_bit      in   1             instruction updates flags
//  exe_wb_en      in   1             writeback enable
//  exe_mem_r_en   in   1             load
//  exe_mem_w_en   in   1             store
//  exe_dest       in   REG_ADDR_W    destination register
//  exe_val_rm     in   REGISTER_LEN  store data
//  mem_valid      out  1             entry presented to MEM
//  mem_ready      in   1             MEM accepts
//  mem_alu_out, mem_wb_en, mem_r_en, mem_w_en, mem_dest, mem_val_rm  out  as above
//  sr_out         out  4             committed flags {Z,C,N,V}; cin = sr_out[2]
// BEHAVIOUR
//  - Reset (async, rst_n=0): both entries invalid, all mem_* outputs 0, sr_out=4'b0,
//    exe_ready=1 after release. Reset mid-transfer discards all in-flight entries.
//  - Accept = exe_valid & exe_ready; transfer = mem_valid & mem_ready.
//  - exe_ready = ~skid_valid (registered; never combinational from mem_ready).
//  - Accept with output empty, or output transferring and skid empty: data -> output
//    reg. Accept while output valid and not transferring: data -> skid, exe_ready=0.
//  - Transfer with skid valid: skid -> output same edge, skid cleared, exe_ready=1.
//  - Latency: EXE->MEM one cycle when unstalled; full throughput with mem_ready=1.
//  - Output entry held stable while mem_valid & ~mem_ready (no field may change).
//  - Flags: on accept with exe_s_bit=1, sr_out <= exe_status at that edge;
//    s_bit=0 or no accept: unchanged. Flag update is not delayed by MEM stalls.
//  - Entries with mem_r_en & mem_w_en both 1 are passed unchanged (no checking).
//  - Order preserved; no entry dropped or duplicated.
// STRUCTURE
//  - Shared inst_defs package: REGISTER_LEN, status-bit index constants
//    (SR_Z=3, SR_C=2, SR_N=1, SR_V=0), packed EXE/MEM bundle width.
//  - Sub-module: status_register (4-bit, async active-low reset, load enable).
//    Skid buffer stays inline.
// TESTING
//  1 Reset: rst_n=0 mid-stream -> mem_valid=0, sr_out=0, all mem_* 0; exe_ready=1 after release.
//  2 Stream: 4 accepts, mem_ready=1, alu_out 1..4 -> mem_alu_out 1..4 on consecutive cycles.
//  3 Stall: mem_ready=0, push A=0x10, B=0x20 -> exe_ready=0, output holds 0x10;
//    release -> 0x10 then 0x20, exe_ready=1 after skid drains.
//  4 Flags: s_bit=1, status=4'b0110 -> sr_out=4'b0110 next edge; s_bit=0,
//    status=4'b1001 -> sr_out unchanged.
//  5 Flags under stall: mem_ready=0, accept with s_bit=1, status=4'b1000 ->
//    sr_out=4'b1000 next edge while entry still waits.
//  6 Store: w_en=1, alu_out=0x100, val_rm=0xDEADBEEF, dest=5 -> all fields identical at MEM.

Source files
------------

// File: rtl/inst_defs_pkg.sv
// Shared EXE/MEM definitions: datapath widths, CPSR flag bit positions and the
// packed bundle that travels from EXE into the MEM stage.
package inst_defs_pkg;

  localparam int REGISTER_LEN = 32;
  localparam int REG_ADDR_W   = 4;

  // CPSR layout {Z,C,N,V}; carry-in for the ALU is SR_C.
  localparam int SR_Z = 3;
  localparam int SR_C = 2;
  localparam int SR_N = 1;
  localparam int SR_V = 0;

  typedef struct packed {
    logic [REGISTER_LEN-1:0] alu_out;
    logic                    wb_en;
    logic                    r_en;
    logic                    w_en;
    logic [REG_ADDR_W-1:0]   dest;
    logic [REGISTER_LEN-1:0] val_rm;
  } exe_mem_bundle_t;

  localparam int BUNDLE_W = $bits(exe_mem_bundle_t);

endpackage

// File: rtl/exe_mem_stage_status_register.sv
// CPSR flag register {Z,C,N,V}: loads the ALU status when enabled, holds otherwise.
module status_register (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] d,
  output logic [3:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= 4'b0000;
    else if (load) q <= d;
  end

endmodule

// File: rtl/exe_mem_stage.sv
// EXE->MEM pipeline boundary: 2-entry skid buffer with valid/ready toward MEM,
// plus the CPSR flag register fed back to EXE.
module exe_mem_stage
  import inst_defs_pkg::*;
#(
  parameter int REGISTER_LEN = inst_defs_pkg::REGISTER_LEN,
  parameter int REG_ADDR_W   = inst_defs_pkg::REG_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    exe_valid,
  output logic                    exe_ready,
  input  logic [REGISTER_LEN-1:0] exe_alu_out,
  input  logic [3:0]              exe_status,
  input  logic                    exe_s_bit,
  input  logic                    exe_wb_en,
  input  logic                    exe_mem_r_en,
  input  logic                    exe_mem_w_en,
  input  logic [REG_ADDR_W-1:0]   exe_dest,
  input  logic [REGISTER_LEN-1:0] exe_val_rm,
  output logic                    mem_valid,
  input  logic                    mem_ready,
  output logic [REGISTER_LEN-1:0] mem_alu_out,
  output logic                    mem_wb_en,
  output logic                    mem_r_en,
  output logic                    mem_w_en,
  output logic [REG_ADDR_W-1:0]   mem_dest,
  output logic [REGISTER_LEN-1:0] mem_val_rm,
  output logic [3:0]              sr_out
);

  exe_mem_bundle_t in_bundle;
  exe_mem_bundle_t out_q;
  exe_mem_bundle_t skid_q;
  logic            out_valid;
  logic            skid_valid;
  logic            accept;
  logic            transfer;

  assign in_bundle = '{alu_out: exe_alu_out, wb_en: exe_wb_en, r_en: exe_mem_r_en,
                       w_en: exe_mem_w_en, dest: exe_dest, val_rm: exe_val_rm};

  // Ready depends only on the skid flop, so mem_ready never reaches exe_ready.
  assign exe_ready = ~skid_valid;
  assign accept    = exe_valid & exe_ready;
  assign transfer  = out_valid & mem_ready;

  // NOTE: data registers are reset as well as the valid bits, because the
  // mem_* outputs must read zero out of reset, not just be marked invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else if (transfer) begin
      if (skid_valid) begin
        out_q      <= skid_q;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_q <= in_bundle;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (!out_valid) begin
      if (accept) begin
        out_q     <= in_bundle;
        out_valid <= 1'b1;
      end
    end else if (accept) begin
      // Output is stalled: park the new entry in the skid slot.
      skid_q     <= in_bundle;
      skid_valid <= 1'b1;
    end
  end

  assign mem_valid   = out_valid;
  assign mem_alu_out = out_q.alu_out;
  assign mem_wb_en   = out_q.wb_en;
  assign mem_r_en    = out_q.r_en;
  assign mem_w_en    = out_q.w_en;
  assign mem_dest    = out_q.dest;
  assign mem_val_rm  = out_q.val_rm;

  // Flags commit at accept time, independent of any MEM back-pressure.
  status_register u_status_register (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept & exe_s_bit),
    .d     (exe_status),
    .q     (sr_out)
  );

endmodule

// File: tb/tb_exe_mem_stage.sv
// Self-checking bench for exe_mem_stage: directed scenarios plus random traffic
// compared against a queue-based model of the stage's in-flight entries.
module tb_exe_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        exe_valid = 1'b0;
  logic        exe_ready;
  logic [31:0] exe_alu_out = '0;
  logic [3:0]  exe_status = '0;
  logic        exe_s_bit = 1'b0;
  logic        exe_wb_en = 1'b0;
  logic        exe_mem_r_en = 1'b0;
  logic        exe_mem_w_en = 1'b0;
  logic [3:0]  exe_dest = '0;
  logic [31:0] exe_val_rm = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_alu_out;
  logic        mem_wb_en;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [3:0]  mem_dest;
  logic [31:0] mem_val_rm;
  logic [3:0]  sr_out;

  always #5 clk = ~clk;

  exe_mem_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .exe_valid    (exe_valid),
    .exe_ready    (exe_ready),
    .exe_alu_out  (exe_alu_out),
    .exe_status   (exe_status),
    .exe_s_bit    (exe_s_bit),
    .exe_wb_en    (exe_wb_en),
    .exe_mem_r_en (exe_mem_r_en),
    .exe_mem_w_en (exe_mem_w_en),
    .exe_dest     (exe_dest),
    .exe_val_rm   (exe_val_rm),
    .mem_valid    (mem_valid),
    .mem_ready    (mem_ready),
    .mem_alu_out  (mem_alu_out),
    .mem_wb_en    (mem_wb_en),
    .mem_r_en     (mem_r_en),
    .mem_w_en     (mem_w_en),
    .mem_dest     (mem_dest),
    .mem_val_rm   (mem_val_rm),
    .sr_out       (sr_out)
  );

  // Model: the stage holds at most two entries, oldest presented to MEM.
  localparam int ENT_W = 71;
  logic [ENT_W-1:0] pending[$];
  logic [3:0]       sr_model = 4'b0000;
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [95:0] observed, input logic [95:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [ENT_W-1:0] exe_entry();
    return {exe_alu_out, exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_dest, exe_val_rm};
  endfunction

  function automatic logic [ENT_W-1:0] mem_entry();
    return {mem_alu_out, mem_wb_en, mem_r_en, mem_w_en, mem_dest, mem_val_rm};
  endfunction

  task automatic compare_model(input string tag);
    check({tag, ".ready"}, 96'(exe_ready), 96'(pending.size() < 2));
    check({tag, ".valid"}, 96'(mem_valid), 96'(pending.size() > 0));
    check({tag, ".sr"},    96'(sr_out),    96'(sr_model));
    if (pending.size() > 0) check({tag, ".entry"}, 96'(mem_entry()), 96'(pending[0]));
  endtask

  // One clock: predict from pre-edge inputs, advance model, sample #1 after edge.
  task automatic cycle(input string tag);
    bit accept;
    bit transfer;
    logic [ENT_W-1:0] e;
    accept   = exe_valid && (pending.size() < 2);
    transfer = (pending.size() > 0) && mem_ready;
    e = exe_entry();
    @(posedge clk);
    if (transfer) void'(pending.pop_front());
    if (accept) begin
      pending.push_back(e);
      if (exe_s_bit) sr_model = exe_status;
    end
    #1;
    compare_model(tag);
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic s,
                       input logic [3:0] st, input logic wb, input logic r,
                       input logic w, input logic [3:0] d, input logic [31:0] rm);
    exe_valid = v; exe_alu_out = alu; exe_s_bit = s; exe_status = st;
    exe_wb_en = wb; exe_mem_r_en = r; exe_mem_w_en = w; exe_dest = d; exe_val_rm = rm;
  endtask

  task automatic drain();
    exe_valid = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle("drain");
    check("drain.empty", 96'(pending.size()), 96'(0));
  endtask

  initial begin
    // Reset state
    #3;
    check("rst.valid", 96'(mem_valid), 96'(0));
    check("rst.sr",    96'(sr_out),    96'(0));
    check("rst.entry", 96'(mem_entry()), 96'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst.ready", 96'(exe_ready), 96'(1));

    // Streaming at full throughput
    mem_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 32'(i), 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'(i), 32'(i * 3));
      cycle("stream");
      check("stream.alu", 96'(mem_alu_out), 96'(i));
      check("stream.valid", 96'(mem_valid), 96'(1));
    end
    drain();

    // Stall with skid fill, then release
    mem_ready = 1'b0;
    drive(1'b1, 32'h10, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'd1, 32'h0);
    cycle("stall.a");
    drive(1'b1, 32'h20, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'd2, 32'h0);
    cycle("stall.b");
    check("stall.ready0", 96'(exe_ready), 96'(0));
    check("stall.holdA", 96'(mem_alu_out), 96'(32'h10));
    exe_valid = 1'b0;
    cycle("stall.hold");
    check("stall.holdA2", 96'(mem_alu_out), 96'(32'h10));
    mem_ready = 1'b1;
    cycle("stall.rel");
    check("stall.B", 96'(mem_alu_out), 96'(32'h20));
    check("stall.ready1", 96'(exe_ready), 96'(1));
    drain();

    // Flag updates
    drive(1'b1, 32'h1, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    cycle("flags.set");
    check("flags.0110", 96'(sr_out), 96'(4'b0110));
    drive(1'b1, 32'h2, 1'b0, 4'b1001, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    cycle("flags.keep");
    check("flags.keep", 96'(sr_out), 96'(4'b0110));
    drain();

    // Flag update while MEM is stalled
    mem_ready = 1'b0;
    drive(1'b1, 32'h3, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    cycle("fstall.a");
    drive(1'b1, 32'h4, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    cycle("fstall.b");
    check("fstall.sr", 96'(sr_out), 96'(4'b1000));
    check("fstall.wait", 96'(mem_alu_out), 96'(32'h3));
    drain();

    // Store entry passes every field through
    drive(1'b1, 32'h100, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'd5, 32'hDEADBEEF);
    cycle("store");
    check("store.fields", 96'(mem_entry()),
          96'({32'h100, 1'b0, 1'b0, 1'b1, 4'd5, 32'hDEADBEEF}));
    drain();

    // Random traffic, including r_en&w_en combinations
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), $urandom);
      mem_ready = 1'($urandom_range(0, 2) != 0);
      cycle("rand");
    end

    // Reset mid-transfer discards in-flight entries
    mem_ready = 1'b0;
    drive(1'b1, 32'h55, 1'b1, 4'b1111, 1'b1, 1'b1, 1'b1, 4'd9, 32'h77);
    cycle("mrst.fill");
    cycle("mrst.fill2");
    rst_n = 1'b0;
    #1;
    pending.delete();
    sr_model = 4'b0000;
    check("mrst.valid", 96'(mem_valid), 96'(0));
    check("mrst.sr",    96'(sr_out),    96'(0));
    check("mrst.entry", 96'(mem_entry()), 96'(0));
    exe_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mrst.ready", 96'(exe_ready), 96'(1));
    cycle("mrst.idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
